// File: rtl/inv_factorial_if.sv
// Request/result bundle for the inverse-factorial unit.
// Master issues start/valor and observes busy/done/valid/n.
// No flow control beyond start being sampled only while the unit is idle.
interface inv_factorial_if;
    logic        start;
    logic [12:0] valor;
    logic        busy;
    logic        done;
    logic        valid;
    logic [2:0]  n;

    modport master (
        output start,
        output valor,
        input  busy,
        input  done,
        input  valid,
        input  n
    );

    modport slave (
        input  start,
        input  valor,
        output busy,
        output done,
        output valid,
        output n
    );
endinterface

// File: rtl/inv_factorial.sv
// Inverse factorial: reports n when valor == n! (n in 0..7) by dividing by 2,3,..,7 bit-serially.
// Latency: 1 cycle for valor 0/1, otherwise 14 cycles per divisor round plus 1 (worst case 85).
// Backpressure: none; start is only accepted in IDLE and ignored while busy or in DONE.
module inv_factorial (
    input  logic           clk,
    input  logic           rst,
    inv_factorial_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DIV, CHECK, DONE} state_t;

    state_t      state, state_nxt;
    logic [12:0] q, q_nxt;
    logic [12:0] quo, quo_nxt;
    logic [2:0]  rem, rem_nxt;
    logic [2:0]  k, k_nxt;
    logic [3:0]  i, i_nxt;
    logic        busy_r, busy_nxt;
    logic        done_r, done_nxt;
    logic        valid_r, valid_nxt;
    logic [2:0]  n_r, n_nxt;

    // Partial remainder with the next dividend bit shifted in; rem < k keeps it within 4 bits.
    logic [3:0]  t;
    logic [3:0]  diff;

    assign t    = {rem, q[i]};
    assign diff = t - {1'b0, k};

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.valid = valid_r;
    assign bus.n     = n_r;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            q       <= '0;
            quo     <= '0;
            rem     <= '0;
            k       <= '0;
            i       <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            n_r     <= '0;
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            quo     <= quo_nxt;
            rem     <= rem_nxt;
            k       <= k_nxt;
            i       <= i_nxt;
            busy_r  <= busy_nxt;
            done_r  <= done_nxt;
            valid_r <= valid_nxt;
            n_r     <= n_nxt;
        end
    end

    // Next-state and next-register values; results are written on entry to DONE.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        quo_nxt   = quo;
        rem_nxt   = rem;
        k_nxt     = k;
        i_nxt     = i;
        busy_nxt  = busy_r;
        done_nxt  = 1'b0;
        valid_nxt = valid_r;
        n_nxt     = n_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    busy_nxt  = 1'b1;
                    valid_nxt = 1'b0;
                    n_nxt     = 3'd0;
                    if (bus.valor == 13'd0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (bus.valor == 13'd1) begin
                        // 0! and 1! both equal 1; the smaller n is reported.
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        valid_nxt = 1'b1;
                    end else begin
                        q_nxt     = bus.valor;
                        k_nxt     = 3'd2;
                        rem_nxt   = 3'd0;
                        quo_nxt   = 13'd0;
                        i_nxt     = 4'd12;
                        state_nxt = DIV;
                    end
                end
            end

            DIV: begin
                if (t >= {1'b0, k}) begin
                    rem_nxt    = diff[2:0];
                    quo_nxt[i] = 1'b1;
                end else begin
                    rem_nxt    = t[2:0];
                    quo_nxt[i] = 1'b0;
                end
                if (i == 4'd0) begin
                    state_nxt = CHECK;
                end else begin
                    i_nxt = i - 4'd1;
                end
            end

            CHECK: begin
                if (rem != 3'd0) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b0;
                    n_nxt     = 3'd0;
                end else if (quo == 13'd1) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                    n_nxt     = k;
                end else if (k == 3'd7) begin
                    // Still divisible after 7: larger than 7!, out of range.
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b0;
                    n_nxt     = 3'd0;
                end else begin
                    q_nxt     = quo;
                    k_nxt     = k + 3'd1;
                    rem_nxt   = 3'd0;
                    quo_nxt   = 13'd0;
                    i_nxt     = 4'd12;
                    state_nxt = DIV;
                end
            end

            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inv_factorial.sv
// Directed bench for inv_factorial: sweep of factorials, rejections, aborts and hold behaviour.
// Cycle 1 is the first cycle after the edge that accepts start; outputs sampled 1ns after each edge.
// Every wait for done is bounded; an expired bound shows up as a wrong done cycle.
module tb_inv_factorial;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    inv_factorial_if bus ();

    inv_factorial u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500us");
        $fatal(1);
    end

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one request from an IDLE cycle and waits (bounded) for done.
    // Optionally pulses start with valor=6 during cycle pulse_cyc to probe busy-time rejection.
    task automatic launch(input logic [12:0] v, input int pulse_cyc,
                          output int cyc, output bit busy_ok);
        bus.start = 1'b1;
        bus.valor = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == pulse_cyc) begin
                bus.start = 1'b1;
                bus.valor = 13'd6;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cyc++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b0;
        bus.start = 1'b1;
        bus.valor = 13'd24;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus.busy, bus.done, bus.valid, bus.n} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs: got busy=%b done=%b valid=%b n=%0d, want all 0",
                         bus.busy, bus.done, bus.valid, bus.n);
            end
        end
        rst = 1'b1;
        bus.start = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_release_idle: got %0d busy/done cycles, want 0", seen);
        end
    endtask

    task automatic test_sweep();
        logic [12:0] vals [7];
        logic [2:0]  ns   [7];
        int          cycs [7];
        int          cyc;
        int          extra;
        bit          bok;
        vals = '{13'd1, 13'd2, 13'd6, 13'd24, 13'd120, 13'd720, 13'd5040};
        ns   = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        cycs = '{1, 15, 29, 43, 57, 71, 85};
        for (int j = 0; j < 7; j++) begin
            launch(vals[j], 0, cyc, bok);
            total++;
            if (cyc != cycs[j]) begin
                bad++;
                $display("FAIL sweep_done_cycle valor=%0d: got %0d, want %0d", vals[j], cyc, cycs[j]);
            end
            total++;
            if (bus.valid !== 1'b1 || bus.n !== ns[j]) begin
                bad++;
                $display("FAIL sweep_result valor=%0d: got valid=%b n=%0d, want valid=1 n=%0d",
                         vals[j], bus.valid, bus.n, ns[j]);
            end
            total++;
            if (!bok) begin
                bad++;
                $display("FAIL sweep_busy valor=%0d: got busy low during op, want high cycles 1..done", vals[j]);
            end
            step(1);
            total++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL sweep_after_done valor=%0d: got busy=%b done=%b, want 0 0",
                         vals[j], bus.busy, bus.done);
            end
            extra = 0;
            repeat (3) begin
                step(1);
                if (bus.done === 1'b1) extra++;
            end
            total++;
            if (extra != 0) begin
                bad++;
                $display("FAIL sweep_single_pulse valor=%0d: got %0d extra done, want 0", vals[j], extra);
            end
        end
    endtask

    task automatic test_reject();
        logic [12:0] vals [4];
        int          cycs [4];
        int          cyc;
        bit          bok;
        vals = '{13'd0, 13'd7, 13'd12, 13'd8190};
        cycs = '{1, 15, 43, 43};
        for (int j = 0; j < 4; j++) begin
            launch(vals[j], 0, cyc, bok);
            total++;
            if (cyc != cycs[j]) begin
                bad++;
                $display("FAIL reject_done_cycle valor=%0d: got %0d, want %0d", vals[j], cyc, cycs[j]);
            end
            total++;
            if (bus.valid !== 1'b0 || bus.n !== 3'd0) begin
                bad++;
                $display("FAIL reject_result valor=%0d: got valid=%b n=%0d, want valid=0 n=0",
                         vals[j], bus.valid, bus.n);
            end
            step(1);
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        int seen;
        bit bok;
        launch(13'd720, 5, cyc, bok);
        total++;
        if (cyc != 71 || bus.valid !== 1'b1 || bus.n !== 3'd6) begin
            bad++;
            $display("FAIL busy_start_ignored: got done_cyc=%0d valid=%b n=%0d, want 71 1 6",
                     cyc, bus.valid, bus.n);
        end
        // start held across the DONE cycle must not be taken.
        bus.start = 1'b1;
        bus.valor = 13'd6;
        step(1);
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b1 || bus.n !== 3'd6) begin
            bad++;
            $display("FAIL done_start_ignored: got busy=%b valid=%b n=%0d, want 0 1 6",
                     bus.busy, bus.valid, bus.n);
        end
        seen = 0;
        repeat (20) begin
            step(1);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL done_start_no_op: got %0d busy/done cycles, want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        bit bok;
        bus.start = 1'b1;
        bus.valor = 13'd5040;
        step(1);
        bus.start = 1'b0;
        step(39);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        total++;
        if ({bus.busy, bus.done, bus.valid, bus.n} !== 6'b0) begin
            bad++;
            $display("FAIL abort_outputs: got busy=%b done=%b valid=%b n=%0d, want all 0",
                     bus.busy, bus.done, bus.valid, bus.n);
        end
        seen = 0;
        repeat (60) begin
            step(1);
            if (bus.done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
        end
        launch(13'd2, 0, cyc, bok);
        total++;
        if (cyc != 15 || bus.valid !== 1'b1 || bus.n !== 3'd2) begin
            bad++;
            $display("FAIL abort_restart: got done_cyc=%0d valid=%b n=%0d, want 15 1 2",
                     cyc, bus.valid, bus.n);
        end
        step(1);
    endtask

    task automatic test_hold_clear();
        int cyc;
        int drift;
        int clr_bad;
        bit bok;
        launch(13'd120, 0, cyc, bok);
        total++;
        if (cyc != 57) begin
            bad++;
            $display("FAIL hold_setup_cycle: got %0d, want 57", cyc);
        end
        drift = 0;
        repeat (10) begin
            step(1);
            if (bus.valid !== 1'b1 || bus.n !== 3'd5) drift++;
        end
        total++;
        if (drift != 0) begin
            bad++;
            $display("FAIL hold_result: got %0d cycles off valid=1 n=5, want 0", drift);
        end
        bus.start = 1'b1;
        bus.valor = 13'd9;
        step(1);
        bus.start = 1'b0;
        cyc = 1;
        clr_bad = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.valid !== 1'b0 || bus.n !== 3'd0) clr_bad++;
            step(1);
            cyc++;
        end
        total++;
        if (clr_bad != 0) begin
            bad++;
            $display("FAIL clear_on_start: got %0d cycles with stale result, want 0", clr_bad);
        end
        total++;
        if (cyc != 15 || bus.valid !== 1'b0 || bus.n !== 3'd0) begin
            bad++;
            $display("FAIL clear_reject9: got done_cyc=%0d valid=%b n=%0d, want 15 0 0",
                     cyc, bus.valid, bus.n);
        end
        step(1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit bok;
        launch(13'd6, 0, cyc, bok);
        total++;
        if (cyc != 29 || bus.valid !== 1'b1 || bus.n !== 3'd3) begin
            bad++;
            $display("FAIL b2b_first: got done_cyc=%0d valid=%b n=%0d, want 29 1 3",
                     cyc, bus.valid, bus.n);
        end
        step(1);
        launch(13'd24, 0, cyc, bok);
        total++;
        if (cyc != 43 || bus.valid !== 1'b1 || bus.n !== 3'd4 || !bok) begin
            bad++;
            $display("FAIL b2b_second: got done_cyc=%0d valid=%b n=%0d busy_ok=%b, want 43 1 4 1",
                     cyc, bus.valid, bus.n, bok);
        end
        step(1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.valor = 13'd0;
        test_reset();
        test_sweep();
        test_reject();
        test_start_while_busy();
        test_reset_mid();
        test_hold_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
